tdm_demux_1to4: RTL and testbench
=================================

# tdm_demux_1to4

Receive-side counterpart of the team's 4-to-1 multiplexer. It takes a time-division-multiplexed stream in which the transmitter cycles its select through inputs 0,1,2,3 and flags slot 0 with a frame sync. It routes each slot's sample to one of four registered outputs, tracks frame alignment, and publishes a complete 4-sample frame with a one-cycle strobe.

## Interface
- W, default 1: sample width; the default matches the 1-bit mux data path.
- SYNC_MISS_MAX, default 2: consecutive sync errors that drop lock (range 1..7).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- din  in  W  sample for the current slot.
- in_valid  in  1  din/frame_sync qualify this cycle; low means stall, no state change.
- frame_sync  in  1  high with the slot-0 sample.
- o0, o1, o2, o3  out  W each  last complete frame (slots 0..3), registered.
- frame_valid  out  1  one-cycle pulse when o0..o3 update.
- locked  out  1  high in LOCKED state.
- slot  out  2  slot index expected for the next accepted beat.
- sync_err  out  1  one-cycle pulse on any alignment error.

## Operation
- Reset (rst_n low at an edge) sets:
  - state HUNT, slot 0, miss count 0, shadow registers 0;
  - o0..o3 = 0; frame_valid, locked, sync_err = 0.
- A beat is accepted only when in_valid = 1.
- HUNT state:
  - Beats without frame_sync are ignored; no sync_err is raised.
  - A beat with frame_sync stores din into shadow[0], sets slot 1, moves to LOCKED, and clears the miss count.
- LOCKED state, normal beat:
  - slot ≠ 0 with frame_sync = 0: store din into shadow[slot], then slot advances by 1.
  - slot = 0 with frame_sync = 1: store into shadow[0], slot becomes 1, miss count clears.
  - slot = 3: o0..o2 take shadow[0..2], o3 takes din, frame_valid pulses, slot wraps to 0.
- LOCKED state, error cases (each pulses sync_err and increments the miss count):
  - Early sync (frame_sync at slot 1..3): discard the partial frame; the beat becomes the new slot 0 (shadow[0] = din, slot 1). No frame_valid.
  - Missing sync (frame_sync = 0 at slot 0): flywheel; the beat is accepted as slot 0 anyway.
  - If the incremented miss count equals SYNC_MISS_MAX, the beat is dropped instead: go to HUNT, slot 0, miss count 0, locked falls.
- o0..o3 hold their value between frames, including through HUNT. Only reset clears them.

## Timing
- Outputs are all registered and have no combinational path from inputs.
- Latency: frame_valid and the new o0..o3 appear in the cycle after the slot-3 beat is accepted.
- locked:
  - Rises in the cycle after the sync beat accepted in HUNT.
  - Falls in the cycle after the beat that reaches SYNC_MISS_MAX.
- sync_err appears the cycle after the offending beat.
- frame_valid pulses at most once per 4 accepted beats.
- Back-to-back frames at full rate give a frame_valid every 4th cycle.
- Stalls (in_valid low) may occur at any slot. They do not advance slot or miss count, and they do not break a frame.
- Reset mid-frame discards the partial frame; the first post-reset beat is evaluated in HUNT.
- Slot-3 beat while frame_sync = 1 is an early-sync error, not a frame completion.

## Structure
- Package tdm_pkg holds:
  - the state enum {HUNT, LOCKED};
  - SLOTS = 4 and the slot index width (2);
  - the miss-count width (3).
- Sub-module tdm_frame_tracker contains the FSM, slot counter and miss counter.
  - It outputs slot, locked, sync_err, plus per-beat strobes: shadow write enable and index, frame complete, frame discard.
- The top level holds the shadow registers and the o0..o3 output registers.

## Test plan
Scenarios 1–4 use W = 4 and SYNC_MISS_MAX = 2.
1. Lock and frame: after reset, send beats {sync+0x1, 0x2, 0x3, 0x4} back-to-back.
   - locked = 1 from the cycle after beat 1.
   - frame_valid pulses once, with o0..o3 = 1,2,3,4; slot returns to 0.
2. Stalls: repeat scenario 1 with in_valid low for 3 cycles between every beat.
   - Same outputs, with frame_valid one cycle after the last beat.
   - slot is unchanged during stalls.
3. Early sync: while locked, send 0xA(sync), 0xB, then 0xC with sync, 0xD, 0xE, 0xF.
   - sync_err pulses once and there is no frame_valid for the A/B frame.
   - Next frame gives o = C,D,E,F; miss count then clears on the following good sync.
4. Lock loss: while locked, omit sync at slot 0 for two consecutive frames.
   - First miss: sync_err, and the frame still completes.
   - Second miss: sync_err, locked falls, the beat is dropped, and o0..o3 keep the last frame.
   - A later sync beat relocks.
5. Reset mid-operation: assert rst_n low after 2 beats of a frame.
   - All outputs are 0, locked = 0, slot = 0.
   - A following non-sync beat raises no sync_err and produces no lock.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 4-slot TDM receive path.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;
    localparam int MISS_W = 3;

endpackage

// File: rtl/tdm_frame_tracker.sv
// Frame-alignment FSM with slot and sync-miss counters; emits per-beat shadow/frame strobes.
// Strobes are combinational from the current beat, status outputs registered; in_valid low freezes state.
module tdm_frame_tracker
    import tdm_pkg::*;
#(
    parameter int SYNC_MISS_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic              frame_sync_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              locked_o,
    output logic              sync_err_o,
    output logic              shadow_we_o,
    output logic [SLOT_W-1:0] shadow_idx_o,
    output logic              frame_done_o,
    output logic              frame_discard_o
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    tdm_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
    logic              sync_err_q, sync_err_d;
    logic              aligned;

    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        miss_d          = miss_q;
        sync_err_d      = 1'b0;
        miss_inc        = miss_q + 1'b1;
        aligned         = (slot_q == '0) == frame_sync_i;
        shadow_we_o     = 1'b0;
        shadow_idx_o    = slot_q;
        frame_done_o    = 1'b0;
        frame_discard_o = 1'b0;

        if (in_valid_i) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync_i) begin
                        state_d      = LOCKED;
                        slot_d       = SLOT_W'(1);
                        miss_d       = '0;
                        shadow_we_o  = 1'b1;
                        shadow_idx_o = '0;
                    end
                end
                LOCKED: begin
                    if (!aligned) begin
                        // Misaligned beat restarts the frame unless it exhausts the miss budget.
                        sync_err_d      = 1'b1;
                        frame_discard_o = (slot_q != '0);
                        if (miss_inc == MISS_W'(SYNC_MISS_MAX)) begin
                            state_d = HUNT;
                            slot_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d       = miss_inc;
                            slot_d       = SLOT_W'(1);
                            shadow_we_o  = 1'b1;
                            shadow_idx_o = '0;
                        end
                    end else begin
                        if (slot_q == '0) begin
                            miss_d = '0;
                        end
                        slot_d = slot_q + 1'b1;
                        if (slot_q == LAST_SLOT) begin
                            frame_done_o = 1'b1;
                        end else begin
                            shadow_we_o = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= '0;
            miss_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            miss_q     <= miss_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign slot_o     = slot_q;
    assign locked_o   = (state_q == LOCKED);
    assign sync_err_o = sync_err_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1-to-4 TDM demultiplexer: gathers slots 0..3 into shadow regs and publishes whole frames.
// Frame outputs one cycle after the slot-3 beat; in_valid low stalls without breaking the frame.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int W             = 1,
    parameter int SYNC_MISS_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              in_valid,
    input  logic              frame_sync,
    output logic [W-1:0]      o0,
    output logic [W-1:0]      o1,
    output logic [W-1:0]      o2,
    output logic [W-1:0]      o3,
    output logic              frame_valid,
    output logic              locked,
    output logic [SLOT_W-1:0] slot,
    output logic              sync_err
);

    logic              shadow_we;
    logic [SLOT_W-1:0] shadow_idx;
    logic              frame_done;
    logic              frame_discard;

    // Slot 3 goes straight to o3, so only slots 0..2 need shadowing.
    logic [W-1:0] shadow_q [0:SLOTS-2];
    logic [W-1:0] o0_q, o1_q, o2_q, o3_q;
    logic         frame_valid_q;

    tdm_frame_tracker #(
        .SYNC_MISS_MAX (SYNC_MISS_MAX)
    ) u_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid_i      (in_valid),
        .frame_sync_i    (frame_sync),
        .slot_o          (slot),
        .locked_o        (locked),
        .sync_err_o      (sync_err),
        .shadow_we_o     (shadow_we),
        .shadow_idx_o    (shadow_idx),
        .frame_done_o    (frame_done),
        .frame_discard_o (frame_discard)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                shadow_q[i] <= '0;
            end
            o0_q          <= '0;
            o1_q          <= '0;
            o2_q          <= '0;
            o3_q          <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= frame_done;
            if (frame_discard) begin
                shadow_q[1] <= '0;
                shadow_q[2] <= '0;
            end
            if (shadow_we) begin
                case (shadow_idx)
                    2'd0:    shadow_q[0] <= din;
                    2'd1:    shadow_q[1] <= din;
                    2'd2:    shadow_q[2] <= din;
                    default: ;
                endcase
            end
            if (frame_done) begin
                o0_q <= shadow_q[0];
                o1_q <= shadow_q[1];
                o2_q <= shadow_q[2];
                o3_q <= din;
            end
        end
    end

    assign o0          = o0_q;
    assign o1          = o1_q;
    assign o2          = o2_q;
    assign o3          = o3_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed scenarios plus randomized TDM traffic checked against a per-beat frame model.
module tb_tdm_demux_1to4;

    localparam int W   = 4;
    localparam int MAX = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         in_valid;
    logic         frame_sync;
    logic [W-1:0] o0, o1, o2, o3;
    logic         frame_valid;
    logic         locked;
    logic [1:0]   slot;
    logic         sync_err;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: what the receiver should look like after each clock edge.
    bit           m_locked;
    int           m_slot;
    int           m_miss;
    logic [W-1:0] m_part [4];
    logic [W-1:0] m_o    [4];
    bit           m_fv;
    bit           m_err;

    tdm_demux_1to4 #(.W(W), .SYNC_MISS_MAX(MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .in_valid    (in_valid),
        .frame_sync  (frame_sync),
        .o0          (o0),
        .o1          (o1),
        .o2          (o2),
        .o3          (o3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_locked = 1'b0;
        m_slot   = 0;
        m_miss   = 0;
        for (int i = 0; i < 4; i++) begin
            m_part[i] = '0;
            m_o[i]    = '0;
        end
        m_fv  = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic void model_beat(input bit v, input bit fs, input logic [W-1:0] d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (fs) begin
                m_locked  = 1'b1;
                m_part[0] = d;
                m_slot    = 1;
                m_miss    = 0;
            end
            return;
        end
        if (fs == (m_slot == 0)) begin
            m_part[m_slot] = d;
            if (m_slot == 0) m_miss = 0;
            if (m_slot == 3) begin
                m_o    = m_part;
                m_fv   = 1'b1;
                m_slot = 0;
            end else begin
                m_slot = m_slot + 1;
            end
        end else begin
            m_err  = 1'b1;
            m_miss = m_miss + 1;
            if (m_miss == MAX) begin
                m_locked = 1'b0;
                m_slot   = 0;
                m_miss   = 0;
            end else begin
                m_part[0] = d;
                m_slot    = 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".o0"},  32'(o0),  32'(m_o[0]));
        chk({tag, ".o1"},  32'(o1),  32'(m_o[1]));
        chk({tag, ".o2"},  32'(o2),  32'(m_o[2]));
        chk({tag, ".o3"},  32'(o3),  32'(m_o[3]));
        chk({tag, ".fv"},  32'(frame_valid), 32'(m_fv));
        chk({tag, ".lock"}, 32'(locked), 32'(m_locked));
        chk({tag, ".slot"}, 32'(slot), 32'(m_slot));
        chk({tag, ".err"}, 32'(sync_err), 32'(m_err));
    endtask

    // Called just after an edge; applies inputs, waits one edge, checks at edge+1.
    task automatic beat(input string tag, input bit v, input bit fs, input logic [W-1:0] d);
        in_valid   = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        model_beat(v, fs, d);
        #1;
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
        rst_n = 1'b1;
    endtask

    task automatic stall(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            beat(tag, 1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        din        = '0;
        model_reset();
        #1;

        // 1: lock and one back-to-back frame
        do_reset("s1.rst");
        chk("s1.rst_lock", 32'(locked), 32'd0);
        chk("s1.rst_slot", 32'(slot), 32'd0);
        beat("s1.b0", 1'b1, 1'b1, 4'h1);
        chk("s1.locked", 32'(locked), 32'd1);
        beat("s1.b1", 1'b1, 1'b0, 4'h2);
        beat("s1.b2", 1'b1, 1'b0, 4'h3);
        beat("s1.b3", 1'b1, 1'b0, 4'h4);
        chk("s1.fv", 32'(frame_valid), 32'd1);
        chk("s1.frame", {16'd0, o0, o1, o2, o3}, 32'h1234);
        chk("s1.slot", 32'(slot), 32'd0);
        beat("s1.idle", 1'b0, 1'b0, 4'h0);
        chk("s1.fv_once", 32'(frame_valid), 32'd0);

        // 2: same frame with three stall cycles between beats
        beat("s2.b0", 1'b1, 1'b1, 4'h1);
        stall("s2.st0", 3);
        chk("s2.slot_hold", 32'(slot), 32'd1);
        beat("s2.b1", 1'b1, 1'b0, 4'h2);
        stall("s2.st1", 3);
        beat("s2.b2", 1'b1, 1'b0, 4'h3);
        stall("s2.st2", 3);
        chk("s2.slot_hold3", 32'(slot), 32'd3);
        beat("s2.b3", 1'b1, 1'b0, 4'h4);
        chk("s2.fv", 32'(frame_valid), 32'd1);
        chk("s2.frame", {16'd0, o0, o1, o2, o3}, 32'h1234);

        // 3: early sync discards A/B frame
        beat("s3.a", 1'b1, 1'b1, 4'hA);
        beat("s3.b", 1'b1, 1'b0, 4'hB);
        beat("s3.c", 1'b1, 1'b1, 4'hC);
        chk("s3.err", 32'(sync_err), 32'd1);
        chk("s3.no_fv", 32'(frame_valid), 32'd0);
        beat("s3.d", 1'b1, 1'b0, 4'hD);
        chk("s3.err_once", 32'(sync_err), 32'd0);
        beat("s3.e", 1'b1, 1'b0, 4'hE);
        beat("s3.f", 1'b1, 1'b0, 4'hF);
        chk("s3.frame", {16'd0, o0, o1, o2, o3}, 32'hCDEF);
        for (int i = 0; i < 4; i++) beat("s3.good", 1'b1, i == 0, 4'(i + 6));

        // 4: two consecutive missing syncs drop lock
        beat("s4.m0", 1'b1, 1'b0, 4'h5);
        chk("s4.err1", 32'(sync_err), 32'd1);
        beat("s4.m1", 1'b1, 1'b0, 4'h6);
        beat("s4.m2", 1'b1, 1'b0, 4'h7);
        beat("s4.m3", 1'b1, 1'b0, 4'h8);
        chk("s4.frame1", {16'd0, o0, o1, o2, o3}, 32'h5678);
        beat("s4.drop", 1'b1, 1'b0, 4'h9);
        chk("s4.err2", 32'(sync_err), 32'd1);
        chk("s4.unlock", 32'(locked), 32'd0);
        chk("s4.hold", {16'd0, o0, o1, o2, o3}, 32'h5678);
        beat("s4.hunt0", 1'b1, 1'b0, 4'h1);
        beat("s4.hunt1", 1'b1, 1'b0, 4'h2);
        beat("s4.relock", 1'b1, 1'b1, 4'h3);
        chk("s4.relocked", 32'(locked), 32'd1);

        // 5: reset mid-frame
        beat("s5.b0", 1'b1, 1'b0, 4'h4);
        beat("s5.b1", 1'b1, 1'b0, 4'h5);
        do_reset("s5.rst");
        chk("s5.zero", {16'd0, o0, o1, o2, o3}, 32'h0);
        chk("s5.slot", 32'(slot), 32'd0);
        beat("s5.nosync", 1'b1, 1'b0, 4'h7);
        chk("s5.no_err", 32'(sync_err), 32'd0);
        chk("s5.no_lock", 32'(locked), 32'd0);

        // 6: random traffic with stalls and occasional sync faults
        begin
            int tx = 0;
            for (int n = 0; n < 600; n++) begin
                bit v, fs;
                v  = ($urandom_range(3) != 0);
                fs = (tx == 0);
                if ($urandom_range(11) == 0) fs = !fs;
                beat("rnd", v, fs, 4'($urandom_range(15)));
                if (v) tx = (tx + 1) % 4;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
